sprite_motion_engine: RTL and testbench
=======================================

// Module: sprite_motion_engine
// PURPOSE
//  Per-frame position engine for a player sprite (Circus-Charlie style runner).
//  Fixed-point X/Y integration, jump/gravity FSM with a parametrised ground line,
//  clamp or wrap horizontal borders, and collision respawn.
//  Sits between the keypad/control logic and the sprite draw/bitmap blocks;
//  it consumes startOfFrame and drives topLeftX/topLeftY.
// PARAMETERS
//  INIT_X      280  respawn X, pixels
//  INIT_Y      400  respawn Y, pixels; must equal GROUND_Y for a grounded spawn
//  FRAC_BITS   6    fraction bits of internal position/speed; scale = 2**FRAC_BITS
//  X_SPEED     64   horizontal step per frame, fixed-point (64 = 1 px)
//  JUMP_SPEED  256  initial upward speed, fixed-point, positive value
//  GRAVITY     64   speed added per frame, fixed-point
//  MAX_FALL    512  downward speed saturation, fixed-point
//  FRAME_W     640  screen width, pixels
//  OBJ_W       32   sprite width, pixels
//  GROUND_Y    400  top-left Y of a standing sprite, pixels
//  X_MODE      0    0 = clamp at borders, 1 = wrap around
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  startOfFrame  in   1   one-cycle pulse per frame; all motion updates happen here
//  move_left     in   1   level; move left while high
//  move_right    in   1   level; move right while high
//  jump_req      in   1   level; a rising edge requests a jump
//  collision     in   1   level; respawn while high
//  topLeftX      out  11  sprite X, integer pixels
//  topLeftY      out  11  sprite Y, integer pixels
//  airborne      out  1   high when FSM is not GROUND
//  landed        out  1   one-cycle pulse on landing
// BEHAVIOUR
//  - Internal x, y, vy: signed 32-bit fixed-point. Outputs are registered: px = pos >>> FRAC_BITS.
//  - Reset and collision both set x=INIT_X<<F, y=INIT_Y<<F, vy=0, state GROUND, and clear jump_pend.
//    Outputs: topLeftX=INIT_X, topLeftY=INIT_Y, airborne=0, landed=0.
//    Reset has priority over collision. Collision has priority over startOfFrame.
//  - Latency: new position is visible on outputs the cycle after the startOfFrame cycle.
//  - jump_req edge detector runs every cycle. A rising edge sets jump_pend.
//  - X (on SOF): dx = +X_SPEED if only right is high, -X_SPEED if only left is high, 0 if both or neither.
//    LIM = (FRAME_W-OBJ_W)<<F.
//    Clamp mode: x' = sat(x+dx, 0, LIM).
//    Wrap mode: if x+dx < 0, add FRAME_W<<F; if x+dx >= FRAME_W<<F, subtract it.
//  - FSM states: GROUND, RISING, FALLING. On each SOF in RISING or FALLING:
//    y' = y+vy; vy' = min(vy+GRAVITY, MAX_FALL).
//    GROUND: if jump_pend on SOF, vy=-JUMP_SPEED, clear jump_pend, go to RISING.
//      Y is not integrated in the jump SOF.
//    RISING: if y' < 0, set y'=0 and vy'=0 (ceiling hit). Go to FALLING when vy' >= 0.
//    FALLING: if y' >= GROUND_Y<<F, set y=GROUND_Y<<F, vy=0, go to GROUND, pulse landed for 1 cycle.
//  - jump_pend while airborne: cleared on the next SOF (no mid-air jump).
//  - Edge and SOF in the same cycle: the edge is taken on that SOF.
//  - X motion is independent of FSM state and continues while airborne.
// CONFIGURATION
//  Macro SPRITE_MOTION_JUMP_BUFFER_EN:
//  - Defined: an edge seen while airborne is held in jump_pend through landing.
//    The jump fires on the first SOF in GROUND, so the landing SOF is not the jump SOF.
//  - Undefined: airborne edges are discarded as above.
// TESTING
//  1. Reset, move_right high for 10 SOFs (X_SPEED=64) -> topLeftX=290, topLeftY=400, airborne=0.
//  2. Clamp mode, INIT_X=600, right for 10 SOFs -> topLeftX stops at 608.
//     Both buttons high -> X stays unchanged.
//  3. Wrap mode, INIT_X=635, right for 10 SOFs -> topLeftX=5; left for 6 SOFs -> topLeftX=639.
//  4. Jump edge then SOFs -> topLeftY=400 on jump SOF, then 396, 393, 391, 390, 390, 391, 393, 396, 400.
//     landed pulses once after the final SOF; airborne then goes to 0.
//  5. collision at mid-jump (Y=391) -> next cycle outputs 280/400, airborne=0.
//     reset+collision together -> same outputs.
//  6. Jump edge at Y=393 while falling.
//     Macro undefined -> no second jump.
//     Macro defined -> RISING starts at the SOF after landing.

Source files
------------

// File: rtl/sprite_motion_engine.sv
// Per-frame fixed-point position engine for a runner sprite: X integration with
// clamp/wrap borders, jump/gravity FSM and collision respawn. Optional macro:
// SPRITE_MOTION_JUMP_BUFFER_EN holds an airborne jump request through landing.
module sprite_motion_engine #(
  parameter int INIT_X     = 280,
  parameter int INIT_Y     = 400,
  parameter int FRAC_BITS  = 6,
  parameter int X_SPEED    = 64,
  parameter int JUMP_SPEED = 256,
  parameter int GRAVITY    = 64,
  parameter int MAX_FALL   = 512,
  parameter int FRAME_W    = 640,
  parameter int OBJ_W      = 32,
  parameter int GROUND_Y   = 400,
  parameter int X_MODE     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump_req,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        airborne,
  output logic        landed
);

  localparam int unsigned POS_W = 32;
  localparam int unsigned PX_W  = 11;

  localparam logic signed [POS_W-1:0] INIT_XF  = POS_W'(INIT_X * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] INIT_YF  = POS_W'(INIT_Y * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] GROUND_F = POS_W'(GROUND_Y * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] LIM_F    = POS_W'((FRAME_W - OBJ_W) * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] WRAP_F   = POS_W'(FRAME_W * (2 ** FRAC_BITS));

  typedef enum logic [1:0] {ST_GROUND, ST_RISING, ST_FALLING} state_e;

  state_e                  state_q, state_d;
  logic signed [POS_W-1:0] x_q, x_d;
  logic signed [POS_W-1:0] y_q, y_d;
  logic signed [POS_W-1:0] vy_q, vy_d;
  logic                    jump_pend_q, jump_pend_d;
  logic                    jump_prev_q, jump_prev_d;
  logic                    landed_q, landed_d;
  logic                    airborne_q, airborne_d;
  logic [PX_W-1:0]         top_left_x_q, top_left_x_d;
  logic [PX_W-1:0]         top_left_y_q, top_left_y_d;

  logic                    jump_edge;
  logic signed [POS_W-1:0] dx, x_sum, x_next, y_int, vy_int;

  // Horizontal step and border handling, evaluated every cycle, applied on SOF
  always_comb begin
    dx = '0;
    if (move_right && !move_left)      dx = POS_W'(X_SPEED);
    else if (move_left && !move_right) dx = -POS_W'(X_SPEED);
    x_sum  = x_q + dx;
    x_next = x_sum;
    if (X_MODE == 0) begin
      if (x_sum < 0)          x_next = '0;
      else if (x_sum > LIM_F) x_next = LIM_F;
    end else begin
      if (x_sum < 0)            x_next = x_sum + WRAP_F;
      else if (x_sum >= WRAP_F) x_next = x_sum - WRAP_F;
    end
    y_int  = y_q + vy_q;
    vy_int = vy_q + POS_W'(GRAVITY);
    if (vy_int > POS_W'(MAX_FALL)) vy_int = POS_W'(MAX_FALL);
  end

  assign jump_edge = jump_req & ~jump_prev_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    jump_pend_d = jump_pend_q;
    jump_prev_d = jump_req;
    landed_d    = 1'b0;

    if (collision) begin
      state_d     = ST_GROUND;
      x_d         = INIT_XF;
      y_d         = INIT_YF;
      vy_d        = '0;
      jump_pend_d = 1'b0;
    end else if (startOfFrame) begin
      x_d = x_next;
      case (state_q)
        ST_GROUND: begin
          if (jump_pend_q || jump_edge) begin
            vy_d        = -POS_W'(JUMP_SPEED);
            jump_pend_d = 1'b0;
            state_d     = ST_RISING;
          end
        end
        ST_RISING: begin
          y_d  = y_int;
          vy_d = vy_int;
          if (y_int < 0) begin
            y_d  = '0;
            vy_d = '0;
          end
          if (vy_d >= 0) state_d = ST_FALLING;
        end
        ST_FALLING: begin
          y_d  = y_int;
          vy_d = vy_int;
          if (y_int >= GROUND_F) begin
            y_d      = GROUND_F;
            vy_d     = '0;
            state_d  = ST_GROUND;
            landed_d = 1'b1;
          end
        end
        default: state_d = ST_GROUND;
      endcase
      // Airborne SOF: either hold the request for after landing or drop it
      if (state_q != ST_GROUND) begin
`ifdef SPRITE_MOTION_JUMP_BUFFER_EN
        jump_pend_d = jump_pend_q | jump_edge;
`else
        jump_pend_d = 1'b0;
`endif
      end
    end else if (jump_edge) begin
      jump_pend_d = 1'b1;
    end

    top_left_x_d = PX_W'(x_d >>> FRAC_BITS);
    top_left_y_d = PX_W'(y_d >>> FRAC_BITS);
    airborne_d   = (state_d != ST_GROUND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GROUND;
      x_q          <= INIT_XF;
      y_q          <= INIT_YF;
      vy_q         <= '0;
      jump_pend_q  <= 1'b0;
      jump_prev_q  <= 1'b0;
      landed_q     <= 1'b0;
      airborne_q   <= 1'b0;
      top_left_x_q <= PX_W'(INIT_X);
      top_left_y_q <= PX_W'(INIT_Y);
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vy_q         <= vy_d;
      jump_pend_q  <= jump_pend_d;
      jump_prev_q  <= jump_prev_d;
      landed_q     <= landed_d;
      airborne_q   <= airborne_d;
      top_left_x_q <= top_left_x_d;
      top_left_y_q <= top_left_y_d;
    end
  end

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;
  assign airborne = airborne_q;
  assign landed   = landed_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine: default, clamp-border and wrap-border
// instances share one stimulus stream; expectations are hand-computed pixels.
module tb_sprite_motion_engine;

  logic clk = 1'b0;
  logic reset, sof, mv_l, mv_r, jreq, coll;

  logic [10:0] d_x, d_y, c_x, c_y, w_x, w_y;
  logic        d_air, d_land, c_air, c_land, w_air, w_land;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sprite_motion_engine dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .move_left(mv_l), .move_right(mv_r),
    .jump_req(jreq), .collision(coll), .topLeftX(d_x), .topLeftY(d_y),
    .airborne(d_air), .landed(d_land));

  sprite_motion_engine #(.INIT_X(600)) dut_clamp (
    .clk(clk), .reset(reset), .startOfFrame(sof), .move_left(mv_l), .move_right(mv_r),
    .jump_req(jreq), .collision(coll), .topLeftX(c_x), .topLeftY(c_y),
    .airborne(c_air), .landed(c_land));

  sprite_motion_engine #(.INIT_X(635), .X_MODE(1)) dut_wrap (
    .clk(clk), .reset(reset), .startOfFrame(sof), .move_left(mv_l), .move_right(mv_r),
    .jump_req(jreq), .collision(coll), .topLeftX(w_x), .topLeftY(w_y),
    .airborne(w_air), .landed(w_land));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // One-cycle SOF pulse after an idle cycle; returns when its result is visible
  task automatic do_sof();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  task automatic jump_pulse();
    @(negedge clk) jreq = 1'b1;
    @(negedge clk) jreq = 1'b0;
  endtask

  int exp_y[10] = '{400, 396, 393, 391, 390, 390, 391, 393, 396, 400};

  initial begin
    reset = 1'b1; sof = 1'b0; mv_l = 1'b0; mv_r = 1'b0; jreq = 1'b0; coll = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x",      int'(d_x), 280);
    check("rst_y",      int'(d_y), 400);
    check("rst_air",    int'(d_air), 0);
    check("rst_land",   int'(d_land), 0);
    check("rst_clamp_x", int'(c_x), 600);
    check("rst_wrap_x",  int'(w_x), 635);

    // Right for 10 frames
    mv_r = 1'b1;
    repeat (10) do_sof();
    check("right_x",    int'(d_x), 290);
    check("right_y",    int'(d_y), 400);
    check("right_air",  int'(d_air), 0);
    check("clamp_hi_x", int'(c_x), 608);
    check("wrap_hi_x",  int'(w_x), 5);

    // Both buttons: no motion
    mv_l = 1'b1;
    repeat (3) do_sof();
    check("both_x",       int'(d_x), 290);
    check("both_clamp_x", int'(c_x), 608);
    check("both_wrap_x",  int'(w_x), 5);

    // Left for 6 frames
    mv_r = 1'b0;
    repeat (6) do_sof();
    check("left_x",       int'(d_x), 284);
    check("left_clamp_x", int'(c_x), 602);
    check("wrap_lo_x",    int'(w_x), 639);
    mv_l = 1'b0;

    // Full jump arc
    jump_pulse();
    for (int i = 0; i < 10; i++) begin
      do_sof();
      check($sformatf("arc_y%0d", i), int'(d_y), exp_y[i]);
      check($sformatf("arc_air%0d", i), int'(d_air), (i < 9) ? 1 : 0);
      check($sformatf("arc_land%0d", i), int'(d_land), (i == 9) ? 1 : 0);
    end
    check("arc_x", int'(d_x), 284);
    @(negedge clk);
    check("post_land",    int'(d_land), 0);
    check("post_air",     int'(d_air), 0);

    // Collision mid-jump at Y=391
    jump_pulse();
    repeat (4) do_sof();
    check("mid_y", int'(d_y), 391);
    @(negedge clk) coll = 1'b1;
    @(negedge clk) coll = 1'b0;
    check("coll_x",   int'(d_x), 280);
    check("coll_y",   int'(d_y), 400);
    check("coll_air", int'(d_air), 0);

    // Reset and collision together
    mv_r = 1'b1;
    repeat (2) do_sof();
    mv_r = 1'b0;
    check("move2_x", int'(d_x), 282);
    @(negedge clk) begin reset = 1'b1; coll = 1'b1; end
    @(negedge clk) begin reset = 1'b0; coll = 1'b0; end
    check("rc_x",   int'(d_x), 280);
    check("rc_y",   int'(d_y), 400);
    check("rc_air", int'(d_air), 0);

    // Jump request while falling at Y=393
    jump_pulse();
    repeat (8) do_sof();
    check("fall_y",   int'(d_y), 393);
    check("fall_air", int'(d_air), 1);
    jump_pulse();
    do_sof();
    check("fall2_y", int'(d_y), 396);
    do_sof();
    check("land2_y",    int'(d_y), 400);
    check("land2_land", int'(d_land), 1);
    do_sof();
`ifdef SPRITE_MOTION_JUMP_BUFFER_EN
    check("buf_air1", int'(d_air), 1);
    check("buf_y1",   int'(d_y), 400);
    do_sof();
    check("buf_air2", int'(d_air), 1);
    check("buf_y2",   int'(d_y), 396);
`else
    check("nobuf_air1", int'(d_air), 0);
    check("nobuf_y1",   int'(d_y), 400);
    do_sof();
    check("nobuf_air2", int'(d_air), 0);
    check("nobuf_y2",   int'(d_y), 400);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
